queue_obj: RTL and testbench



---
 rtl/queue_obj.sv | 108 ++++++++++
 tb/tb_queue_obj.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/queue_obj.sv
// Circular FIFO with registered pop output and combinational head peek.
// Optional same-cycle empty-queue bypass is enabled by defining QUEUE_BYPASS_EN.
module queue_obj #(
    parameter int    LENGTH  = 8,
    parameter int    WIDTH   = 64,
    parameter bit    SPECIAL = 1'b0,
    parameter string TAG     = ""
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             stall,
    input  logic             flush,
    input  logic             enque,
    input  logic [WIDTH-1:0] enque_data,
    input  logic             deque,
    output logic [WIDTH-1:0] deque_data,
    output logic [WIDTH-1:0] r_mapping,
    output logic             halt
);

    localparam int PW = $clog2(LENGTH);
    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] FULL     = CW'(LENGTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(SPECIAL ? LENGTH : 0);
    localparam logic [PW-1:0] LAST     = PW'(LENGTH - 1);

    logic [WIDTH-1:0] mem [LENGTH];
    logic [PW-1:0]    rd;
    logic [PW-1:0]    wr;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL);

`ifdef QUEUE_BYPASS_EN
    assign bypass = enque && deque && !stall && empty && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Full/empty decisions use the pre-edge count so push and pop can coexist.
    assign push = enque && !full && !bypass && !flush;
    assign pop  = deque && !stall && !empty && !flush;

    assign halt      = full;
    assign r_mapping = empty ? '0 : mem[rd];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd         <= '0;
            wr         <= '0;
            cnt        <= CNT_INIT;
            deque_data <= '0;
        end else if (flush) begin
            rd         <= '0;
            wr         <= '0;
            cnt        <= CNT_INIT;
            deque_data <= '0;
        end else begin
            if (push) wr <= next_ptr(wr);
            if (pop)  rd <= next_ptr(rd);
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
            if (deque && !stall)
                deque_data <= bypass ? enque_data : (empty ? '0 : mem[rd]);
            else if (!stall)
                deque_data <= '0;
        end
    end

    // Free-list mode needs the storage itself preset to the tag range.
    generate
        if (SPECIAL) begin : g_fill
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    for (int i = 0; i < LENGTH; i++) mem[i] <= WIDTH'(LENGTH + i);
                end else if (flush) begin
                    for (int i = 0; i < LENGTH; i++) mem[i] <= WIDTH'(LENGTH + i);
                end else if (push) begin
                    mem[wr] <= enque_data;
                end
            end
        end else begin : g_plain
            always_ff @(posedge CLK) begin
                if (push) mem[wr] <= enque_data;
            end
        end
    endgenerate

    always @(posedge CLK) begin
        if (RESET) begin
            assert (cnt <= FULL)
            else $error("queue_obj %s: count %0d exceeds %0d", TAG, cnt, LENGTH);
        end
    end

endmodule

// File: tb/tb_queue_obj.sv
// Randomized and directed checks of queue_obj against a queue-based reference model,
// plus a free-list (SPECIAL) instance.
module tb_queue_obj;

    localparam int L  = 8;
    localparam int W  = 64;
    localparam int FL = 32;
    localparam int FW = 16;
`ifdef QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          stall, flush, enque, deque;
    logic [W-1:0]  enque_data, deque_data, r_mapping;
    logic          halt;

    logic          fl_stall, fl_flush, fl_enque, fl_deque;
    logic [FW-1:0] fl_enque_data, fl_deque_data, fl_r_mapping;
    logic          fl_halt;

    always #5 CLK = ~CLK;

    queue_obj #(.LENGTH(L), .WIDTH(W), .SPECIAL(1'b0), .TAG("main")) dut (
        .CLK(CLK), .RESET(RESET), .stall(stall), .flush(flush),
        .enque(enque), .enque_data(enque_data), .deque(deque),
        .deque_data(deque_data), .r_mapping(r_mapping), .halt(halt)
    );

    queue_obj #(.LENGTH(FL), .WIDTH(FW), .SPECIAL(1'b1), .TAG("freelist")) dut_fl (
        .CLK(CLK), .RESET(RESET), .stall(fl_stall), .flush(fl_flush),
        .enque(fl_enque), .enque_data(fl_enque_data), .deque(fl_deque),
        .deque_data(fl_deque_data), .r_mapping(fl_r_mapping), .halt(fl_halt)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] q[$];
    logic [63:0] m_dd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " deque_data"}, deque_data, m_dd);
        check({tag, " halt"}, 64'(halt), 64'(q.size() == L));
        check({tag, " r_mapping"}, r_mapping, (q.size() != 0) ? q[0] : 64'h0);
    endtask

    // Reference behaviour of one clock edge, from the pre-edge queue contents.
    task automatic model_edge(input logic e, input logic [63:0] d, input logic dq,
                              input logic s, input logic f);
        bit was_full, was_empty;
        if (f) begin
            q.delete();
            m_dd = '0;
            return;
        end
        was_full  = (q.size() == L);
        was_empty = (q.size() == 0);
        if (BYP && e && dq && !s && was_empty) begin
            m_dd = d;
            return;
        end
        if (dq && !s) m_dd = was_empty ? 64'h0 : q.pop_front();
        else if (!s)  m_dd = '0;
        if (e && !was_full) q.push_back(d);
    endtask

    task automatic cycle(input logic e, input logic [63:0] d, input logic dq,
                         input logic s, input logic f, input string tag);
        enque = e; enque_data = d; deque = dq; stall = s; flush = f;
        @(posedge CLK);
        model_edge(e, d, dq, s, f);
        @(negedge CLK);
        check_all(tag);
    endtask

    initial begin
        RESET = 1'b0;
        {stall, flush, enque, deque} = '0;
        enque_data = '0;
        {fl_stall, fl_flush, fl_enque, fl_deque} = '0;
        fl_enque_data = '0;
        m_dd = '0;
        repeat (2) @(negedge CLK);
        check_all("reset");
        check("fl reset r_mapping", 64'(fl_r_mapping), 64'd32);
        check("fl reset halt", 64'(fl_halt), 64'd1);
        check("fl reset deque_data", 64'(fl_deque_data), 64'd0);
        RESET = 1'b1;

        // free-list pops and refill on flush
        fl_deque = 1'b1;
        @(negedge CLK);
        check("fl pop0", 64'(fl_deque_data), 64'd32);
        @(negedge CLK);
        check("fl pop1", 64'(fl_deque_data), 64'd33);
        check("fl head after pops", 64'(fl_r_mapping), 64'd34);
        check("fl halt after pops", 64'(fl_halt), 64'd0);
        fl_deque = 1'b0;
        fl_flush = 1'b1;
        @(negedge CLK);
        fl_flush = 1'b0;
        check("fl flush r_mapping", 64'(fl_r_mapping), 64'd32);
        check("fl flush halt", 64'(fl_halt), 64'd1);
        check("fl flush deque_data", 64'(fl_deque_data), 64'd0);

        // pipelined push/pop: first pop is a bubble
        cycle(1, 64'hA1, 1, 0, 0, "pp1");
        if (!BYP) check("pp1 const", deque_data, 64'h0);
        cycle(1, 64'hA2, 1, 0, 0, "pp2");
        if (!BYP) check("pp2 const", deque_data, 64'hA1);
        cycle(1, 64'hA3, 1, 0, 0, "pp3");
        if (!BYP) check("pp3 const", deque_data, 64'hA2);
        cycle(0, 64'h0, 1, 0, 0, "pp4");
        if (!BYP) check("pp4 const", deque_data, 64'hA3);
        cycle(0, 64'h0, 0, 0, 0, "pp5");

        // fill to full, dropped push, drain in order
        for (int i = 0; i < L; i++) cycle(1, 64'h10 + 64'(i), 0, 0, 0, "fill");
        check("full halt const", 64'(halt), 64'd1);
        cycle(1, 64'hFF, 0, 0, 0, "drop");
        for (int i = 0; i < L; i++) begin
            cycle(0, 64'h0, 1, 0, 0, "drain");
            check("drain const", deque_data, 64'h10 + 64'(i));
        end
        cycle(0, 64'h0, 1, 0, 0, "drain empty");
        check("drain empty const", deque_data, 64'h0);

        // stall holds output and contents
        for (int i = 0; i < 4; i++) cycle(1, 64'h20 + 64'(i), 0, 0, 0, "st fill");
        cycle(0, 64'h0, 1, 0, 0, "st pop");
        for (int i = 0; i < 4; i++) begin
            cycle(0, 64'h0, 1, 1, 0, "stalled");
            check("stalled const", deque_data, 64'h20);
        end
        for (int i = 0; i < 4; i++) cycle(0, 64'h0, 1, 0, 0, "st resume");

        // continuous traffic across the pointer wrap
        for (int i = 0; i < 20; i++) cycle(1, 64'h100 + 64'(i), 1, 0, 0, "wrap");
        cycle(0, 64'h0, 1, 0, 0, "wrap tail");

        // flush beats a simultaneous push
        for (int i = 0; i < 5; i++) cycle(1, 64'h30 + 64'(i), 0, 0, 0, "fl fill");
        cycle(1, 64'h3F, 1, 0, 1, "flush");
        check("flush r_mapping const", r_mapping, 64'h0);
        cycle(0, 64'h0, 1, 0, 0, "post flush");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic e, dq, s, f;
            e  = ($urandom_range(0, 99) < 55);
            dq = ($urandom_range(0, 99) < 50);
            s  = dq && ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 49) == 0);
            cycle(e, {$urandom, $urandom}, dq, s, f, "rand");
        end

        // asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cycle(1, 64'h50 + 64'(i), 1, 0, 0, "pre rst");
        enque = 1'b0; deque = 1'b0;
        RESET = 1'b0;
        #1;
        q.delete();
        m_dd = '0;
        check_all("async rst");
        check("async rst fl r_mapping", 64'(fl_r_mapping), 64'd32);
        @(negedge CLK);
        RESET = 1'b1;
        cycle(1, 64'h77, 1, 0, 0, "after rst");
        cycle(0, 64'h0, 1, 0, 0, "after rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
